// File: rtl/surf_debug_capture_pkg.sv
// Shared types and defaults for the SURF debug capture block.
package surf_debug_capture_pkg;

  localparam int DATA_W_DEF = 35;
  localparam int ADDR_W_DEF = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/surf_debug_capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
module surf_debug_capture_ram #(
  parameter int DATA_W = 35,
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  // No reset on the array or read register so the buffer maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/surf_debug_capture.sv
// Circular-buffer logic analyser with programmable pre-trigger depth; freezes on completion
// and reads back oldest-first with one cycle of latency.
module surf_debug_capture
  import surf_debug_capture_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [DATA_W-1:0] debug_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] pretrig_i,
  input  logic [DATA_W-1:0] trig_mask_i,
  input  logic [DATA_W-1:0] trig_value_i,
  input  logic              ext_trig_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic [2:0]        state_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] trig_addr_o
);

  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] pretrig_q, pretrig_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic              rd_valid_q, rd_valid_d;
  logic              have_data_q, have_data_d;

  logic              capturing;
  logic              trig;
  logic              rd_fire;
  logic [ADDR_W-1:0] post_len;
  logic [ADDR_W-1:0] rd_phys;
  logic [DATA_W-1:0] ram_rd_data;

  assign capturing = state_q inside {ST_PRE, ST_ARMED, ST_POST};
  assign trig      = ext_trig_i |
                     ((|trig_mask_i) & (((debug_i ^ trig_value_i) & trig_mask_i) == '0));
  // Samples still to write after the trigger sample; pretrig + 1 + post_len == DEPTH.
  assign post_len  = LAST - pretrig_q;
  assign rd_fire   = rd_en_i & (state_q == ST_DONE);
  assign rd_phys   = trig_addr_q - pretrig_q + rd_addr_i;

  always_comb begin
    state_d     = state_q;
    wptr_d      = capturing ? wptr_q + ONE : wptr_q;
    cnt_d       = cnt_q;
    pretrig_d   = pretrig_q;
    trig_addr_d = trig_addr_q;
    rd_valid_d  = rd_fire;
    have_data_d = have_data_q | rd_fire;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm_i) begin
            // pretrig_i is ADDR_W wide, so it can never exceed DEPTH-1.
            state_d     = (pretrig_i == '0) ? ST_ARMED : ST_PRE;
            wptr_d      = '0;
            cnt_d       = '0;
            pretrig_d   = pretrig_i;
            trig_addr_d = '0;
          end
        end
        ST_PRE: begin
          cnt_d = cnt_q + ONE;
          if (cnt_q == pretrig_q - ONE) begin
            state_d = ST_ARMED;
            cnt_d   = '0;
          end
        end
        ST_ARMED: begin
          if (trig) begin
            trig_addr_d = wptr_q;
            cnt_d       = '0;
            state_d     = (post_len == '0) ? ST_DONE : ST_POST;
          end
        end
        ST_POST: begin
          cnt_d = cnt_q + ONE;
          if (cnt_q == post_len - ONE) state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      wptr_q      <= '0;
      cnt_q       <= '0;
      pretrig_q   <= '0;
      trig_addr_q <= '0;
      rd_valid_q  <= 1'b0;
      have_data_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      cnt_q       <= cnt_d;
      pretrig_q   <= pretrig_d;
      trig_addr_q <= trig_addr_d;
      rd_valid_q  <= rd_valid_d;
      have_data_q <= have_data_d;
    end
  end

  surf_debug_capture_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i     (clk_i),
    .wr_en_i   (capturing),
    .wr_addr_i (wptr_q),
    .wr_data_i (debug_i),
    .rd_en_i   (rd_fire),
    .rd_addr_i (rd_phys),
    .rd_data_o (ram_rd_data)
  );

  // Read data stays zero from reset until the first read of a completed capture.
  assign rd_data_o   = have_data_q ? ram_rd_data : '0;
  assign rd_valid_o  = rd_valid_q;
  assign state_o     = state_q;
  assign done_o      = (state_q == ST_DONE);
  assign trig_addr_o = trig_addr_q;

endmodule
